bp_be_regfile_wport_sched: RTL and testbench

//  Schedules integer writebacks onto the two regfile write ports (rd_w_v/rd_addr/rd_data[1:0]) of the dual-issue BE.
//  Two in-order pipe writebacks always win; long-latency returns (mem miss, mul/div, CSR) are

---
 rtl/bp_be_regfile_wport_sched.sv | 184 ++++++++++++++++++
 tb/tb_bp_be_regfile_wport_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_regfile_wport_sched.sv
// Regfile write-port scheduler for the dual-issue BE.
// Pipe writebacks own their port. Late writebacks are round-robin arbitrated into a FIFO
// and drained into whichever ports the pipes leave idle.
// Optional stall statistics: define BP_BE_WPORT_SCHED_STATS_EN.
module bp_be_regfile_wport_sched #(
  parameter int unsigned data_width_p     = 64,
  parameter int unsigned reg_addr_width_p = 5,
  parameter int unsigned late_els_p       = 3,
  parameter int unsigned queue_els_p      = 4,
  parameter int unsigned zero_x0_p        = 1
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic [1:0]                                   pipe_v_i,
  input  logic [1:0][reg_addr_width_p-1:0]             pipe_addr_i,
  input  logic [1:0][data_width_p-1:0]                 pipe_data_i,
  input  logic [late_els_p-1:0]                        late_v_i,
  input  logic [late_els_p-1:0][reg_addr_width_p-1:0]  late_addr_i,
  input  logic [late_els_p-1:0][data_width_p-1:0]      late_data_i,
  output logic [late_els_p-1:0]                        late_ready_o,
  output logic [1:0]                                   rd_w_v_o,
  output logic [1:0][reg_addr_width_p-1:0]             rd_addr_o,
  output logic [1:0][data_width_p-1:0]                 rd_data_o,
  output logic                                         queue_empty_o,
  output logic [15:0]                                  stall_cnt_o
);

  localparam int unsigned QPtrW = $clog2(queue_els_p);
  localparam int unsigned CntW  = $clog2(queue_els_p + 1);
  localparam int unsigned RrW   = (late_els_p > 1) ? $clog2(late_els_p) : 1;
  localparam logic        DropX0 = (zero_x0_p != 0);

  logic [RrW-1:0]              rr_q, rr_d;
  logic [QPtrW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]             count_q, count_d;
  logic [reg_addr_width_p-1:0] addr_mem [queue_els_p];
  logic [data_width_p-1:0]     data_mem [queue_els_p];

  logic [late_els_p-1:0]       grant;
  logic                        found;
  int                          grant_idx;
  int                          idx;
  logic                        full, hs_v, enq;
  logic [reg_addr_width_p-1:0] enq_addr;
  logic [data_width_p-1:0]     enq_data;

  logic [1:0]                             pipe_wr, free, deq_v;
  logic [1:0][reg_addr_width_p-1:0]       deq_addr;
  logic [1:0][data_width_p-1:0]           deq_data;
  logic [1:0]                             n_deq;
  logic                                   have1, have2;
  logic [QPtrW-1:0]                       rd_ptr_p1;

  // Round-robin pick of the first valid late requester starting at the pointer.
  always_comb begin
    grant     = '0;
    found     = 1'b0;
    grant_idx = 0;
    idx       = 0;
    for (int i = 0; i < int'(late_els_p); i++) begin
      idx = (int'(rr_q) + i) % int'(late_els_p);
      if (!found && late_v_i[RrW'(idx)]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found) grant[RrW'(grant_idx)] = 1'b1;
  end

  // Readiness uses the pre-dequeue count: a dequeue never frees a slot in the same cycle.
  assign full         = (count_q == CntW'(queue_els_p));
  assign late_ready_o = grant & {late_els_p{~full}};
  assign hs_v         = |(late_v_i & late_ready_o);
  assign enq_addr     = late_addr_i[RrW'(grant_idx)];
  assign enq_data     = late_data_i[RrW'(grant_idx)];
  // x0 writes complete the handshake but are silently dropped.
  assign enq          = hs_v && !(DropX0 && (enq_addr == '0));
  assign rr_d         = hs_v ? RrW'((grant_idx + 1) % int'(late_els_p)) : rr_q;

  // A pipe write to x0 leaves its port free for the FIFO.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      pipe_wr[k] = pipe_v_i[k] && !(DropX0 && (pipe_addr_i[k] == '0));
    end
  end
  assign free      = ~pipe_wr;
  assign have1     = (count_q != '0);
  assign have2     = (count_q >= CntW'(2));
  assign rd_ptr_p1 = rd_ptr_q + QPtrW'(1);

  // Oldest entry goes to the lowest-index free port; second oldest only if both are free.
  always_comb begin
    deq_v    = '0;
    deq_addr = '0;
    deq_data = '0;
    n_deq    = 2'd0;
    case (free)
      2'b11: begin
        if (have1) begin
          deq_v[0]    = 1'b1;
          deq_addr[0] = addr_mem[rd_ptr_q];
          deq_data[0] = data_mem[rd_ptr_q];
          n_deq       = 2'd1;
        end
        if (have2) begin
          deq_v[1]    = 1'b1;
          deq_addr[1] = addr_mem[rd_ptr_p1];
          deq_data[1] = data_mem[rd_ptr_p1];
          n_deq       = 2'd2;
        end
      end
      2'b01: begin
        if (have1) begin
          deq_v[0]    = 1'b1;
          deq_addr[0] = addr_mem[rd_ptr_q];
          deq_data[0] = data_mem[rd_ptr_q];
          n_deq       = 2'd1;
        end
      end
      2'b10: begin
        if (have1) begin
          deq_v[1]    = 1'b1;
          deq_addr[1] = addr_mem[rd_ptr_q];
          deq_data[1] = data_mem[rd_ptr_q];
          n_deq       = 2'd1;
        end
      end
      default: ;
    endcase
  end

  assign count_d = count_q + CntW'(enq) - CntW'(n_deq);

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_mem[wr_ptr_q] <= enq_addr;
      data_mem[wr_ptr_q] <= enq_data;
    end
  end

  // FIFO pointers, count, arbiter pointer and registered write ports.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_w_v_o  <= '0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else begin
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_q + QPtrW'(enq);
      rd_ptr_q <= rd_ptr_q + QPtrW'(n_deq);
      count_q  <= count_d;
      for (int k = 0; k < 2; k++) begin
        rd_w_v_o[k]  <= pipe_wr[k] | deq_v[k];
        rd_addr_o[k] <= pipe_wr[k] ? pipe_addr_i[k] : deq_addr[k];
        rd_data_o[k] <= pipe_wr[k] ? pipe_data_i[k] : deq_data[k];
      end
    end
  end

  assign queue_empty_o = (count_q == '0);

`ifdef BP_BE_WPORT_SCHED_STATS_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles where some late requester waited.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
    end else if ((|(late_v_i & ~late_ready_o)) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_regfile_wport_sched.sv
// Directed self-checking bench for bp_be_regfile_wport_sched (default parameters).
module tb_bp_be_regfile_wport_sched;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [1:0]      pipe_v_i;
  logic [1:0][4:0] pipe_addr_i;
  logic [1:0][63:0] pipe_data_i;
  logic [2:0]      late_v_i;
  logic [2:0][4:0] late_addr_i;
  logic [2:0][63:0] late_data_i;
  logic [2:0]      late_ready_o;
  logic [1:0]      rd_w_v_o;
  logic [1:0][4:0] rd_addr_o;
  logic [1:0][63:0] rd_data_o;
  logic            queue_empty_o;
  logic [15:0]     stall_cnt_o;

  int checks = 0;
  int errors = 0;

  bp_be_regfile_wport_sched dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .pipe_v_i      (pipe_v_i),
    .pipe_addr_i   (pipe_addr_i),
    .pipe_data_i   (pipe_data_i),
    .late_v_i      (late_v_i),
    .late_addr_i   (late_addr_i),
    .late_data_i   (late_data_i),
    .late_ready_o  (late_ready_o),
    .rd_w_v_o      (rd_w_v_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_o     (rd_data_o),
    .queue_empty_o (queue_empty_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_v_i    = '0;
    pipe_addr_i = '0;
    pipe_data_i = '0;
    late_v_i    = '0;
    late_addr_i = '0;
    late_data_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rd_w_v_o !== 2'b00) begin
      errors++; $display("FAIL reset_wv got %b exp 00", rd_w_v_o);
    end
    checks++;
    if (rd_addr_o !== '0) begin
      errors++; $display("FAIL reset_addr got %h exp 0", rd_addr_o);
    end
    checks++;
    if (rd_data_o !== '0) begin
      errors++; $display("FAIL reset_data got %h exp 0", rd_data_o);
    end
    checks++;
    if (queue_empty_o !== 1'b1) begin
      errors++; $display("FAIL reset_empty got %b exp 1", queue_empty_o);
    end
    checks++;
    if (stall_cnt_o !== 16'd0) begin
      errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt_o);
    end
    checks++;
    if (late_ready_o !== 3'b000) begin
      errors++; $display("FAIL reset_ready got %b exp 000", late_ready_o);
    end
  endtask

  task automatic test_pipe();
    pipe_v_i       = 2'b11;
    pipe_addr_i[0] = 5'd5;
    pipe_addr_i[1] = 5'd7;
    pipe_data_i[0] = 64'hA;
    pipe_data_i[1] = 64'hB;
    tick();
    checks++;
    if (rd_w_v_o !== 2'b11) begin
      errors++; $display("FAIL pipe_wv got %b exp 11", rd_w_v_o);
    end
    checks++;
    if (rd_addr_o[0] !== 5'd5 || rd_addr_o[1] !== 5'd7) begin
      errors++; $display("FAIL pipe_addr got %0d/%0d exp 5/7", rd_addr_o[0], rd_addr_o[1]);
    end
    checks++;
    if (rd_data_o[0] !== 64'hA || rd_data_o[1] !== 64'hB) begin
      errors++; $display("FAIL pipe_data got %h/%h exp a/b", rd_data_o[0], rd_data_o[1]);
    end
    idle_inputs();
    tick();
    checks++;
    if (rd_w_v_o !== 2'b00) begin
      errors++; $display("FAIL pipe_idle_wv got %b exp 00", rd_w_v_o);
    end
  endtask

  // All three requesters held; one handshake and one drain per cycle, always on port 0.
  task automatic test_round_robin();
    logic [2:0] exp_g;
    int         p;
    for (int c = 0; c < 6; c++) begin
      late_v_i = 3'b111;
      for (int i = 0; i < 3; i++) begin
        late_addr_i[i] = 5'(10 + i);
        late_data_i[i] = 64'(16 * c + i);
      end
      #1;
      exp_g = 3'b001 << (c % 3);
      checks++;
      if (late_ready_o !== exp_g) begin
        errors++; $display("FAIL rr_grant c=%0d got %b exp %b", c, late_ready_o, exp_g);
      end
      tick();
      if (c == 0) begin
        checks++;
        if (rd_w_v_o !== 2'b00) begin
          errors++; $display("FAIL rr_latency got %b exp 00", rd_w_v_o);
        end
      end else begin
        p = (c - 1) % 3;
        checks++;
        if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'(10 + p) ||
            rd_data_o[0] !== 64'(16 * (c - 1) + p)) begin
          errors++;
          $display("FAIL rr_drain c=%0d got v=%b a=%0d d=%h exp v=01 a=%0d d=%h", c, rd_w_v_o,
                   rd_addr_o[0], rd_data_o[0], 10 + p, 16 * (c - 1) + p);
        end
      end
    end
    late_v_i = '0;
    tick();
    checks++;
    if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd12 || rd_data_o[0] !== 64'd82) begin
      errors++;
      $display("FAIL rr_last got v=%b a=%0d d=%h exp v=01 a=12 d=52", rd_w_v_o, rd_addr_o[0],
               rd_data_o[0]);
    end
    tick();
    checks++;
    if (rd_w_v_o !== 2'b00 || queue_empty_o !== 1'b1) begin
      errors++; $display("FAIL rr_end got v=%b e=%b exp v=00 e=1", rd_w_v_o, queue_empty_o);
    end
  endtask

  // Both pipes busy: FIFO fills to 4, then blocks; drains two per cycle once pipes drop.
  task automatic test_full_drain();
    logic [15:0] exp_stall;
`ifdef BP_BE_WPORT_SCHED_STATS_EN
    exp_stall = 16'd2;
`else
    exp_stall = 16'd0;
`endif
    do_reset();
    for (int c = 0; c < 6; c++) begin
      pipe_v_i       = 2'b11;
      pipe_addr_i[0] = 5'd1;
      pipe_addr_i[1] = 5'd2;
      pipe_data_i[0] = 64'(c);
      pipe_data_i[1] = 64'(c + 100);
      late_v_i       = 3'b001;
      late_addr_i[0] = 5'(20 + c);
      late_data_i[0] = 64'(512 + c);
      #1;
      checks++;
      if (late_ready_o !== ((c < 4) ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL full_ready c=%0d got %b", c, late_ready_o);
      end
      tick();
      checks++;
      if (rd_w_v_o !== 2'b11 || rd_data_o[0] !== 64'(c)) begin
        errors++; $display("FAIL full_pipe c=%0d got v=%b d=%h", c, rd_w_v_o, rd_data_o[0]);
      end
    end
    checks++;
    if (stall_cnt_o !== exp_stall) begin
      errors++; $display("FAIL full_stall got %0d exp %0d", stall_cnt_o, exp_stall);
    end
    checks++;
    if (queue_empty_o !== 1'b0) begin
      errors++; $display("FAIL full_nonempty got %b exp 0", queue_empty_o);
    end
    idle_inputs();
    for (int d = 0; d < 2; d++) begin
      tick();
      checks++;
      if (rd_w_v_o !== 2'b11 || rd_addr_o[0] !== 5'(20 + 2 * d) ||
          rd_addr_o[1] !== 5'(21 + 2 * d) || rd_data_o[0] !== 64'(512 + 2 * d) ||
          rd_data_o[1] !== 64'(513 + 2 * d)) begin
        errors++;
        $display("FAIL drain d=%0d got v=%b a=%0d/%0d d=%h/%h exp a=%0d/%0d", d, rd_w_v_o,
                 rd_addr_o[0], rd_addr_o[1], rd_data_o[0], rd_data_o[1], 20 + 2 * d, 21 + 2 * d);
      end
    end
    checks++;
    if (queue_empty_o !== 1'b1) begin
      errors++; $display("FAIL drain_empty got %b exp 1", queue_empty_o);
    end
  endtask

  task automatic test_x0();
    // Queue one entry while both pipes are busy.
    pipe_v_i       = 2'b11;
    pipe_addr_i[0] = 5'd3;
    pipe_addr_i[1] = 5'd4;
    late_v_i       = 3'b001;
    late_addr_i[0] = 5'd9;
    late_data_i[0] = 64'h55;
    tick();
    idle_inputs();
    pipe_v_i       = 2'b01;
    pipe_addr_i[0] = 5'd0;
    pipe_data_i[0] = 64'hDEAD;
    tick();
    checks++;
    if (rd_w_v_o !== 2'b01 || rd_addr_o[0] !== 5'd9 || rd_data_o[0] !== 64'h55) begin
      errors++;
      $display("FAIL x0_pipe got v=%b a=%0d d=%h exp v=01 a=9 d=55", rd_w_v_o, rd_addr_o[0],
               rd_data_o[0]);
    end
    idle_inputs();
    late_v_i       = 3'b001;
    late_addr_i[0] = 5'd0;
    late_data_i[0] = 64'h77;
    #1;
    checks++;
    if (late_ready_o !== 3'b001) begin
      errors++; $display("FAIL x0_late_ready got %b exp 001", late_ready_o);
    end
    tick();
    late_v_i = '0;
    checks++;
    if (queue_empty_o !== 1'b1) begin
      errors++; $display("FAIL x0_late_dropped got empty=%b exp 1", queue_empty_o);
    end
    tick();
    checks++;
    if (rd_w_v_o !== 2'b00) begin
      errors++; $display("FAIL x0_late_port got %b exp 00", rd_w_v_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      pipe_v_i       = 2'b11;
      pipe_addr_i[0] = 5'd6;
      pipe_addr_i[1] = 5'd8;
      late_v_i       = 3'b010;
      late_addr_i[1] = 5'(25 + c);
      tick();
    end
    checks++;
    if (queue_empty_o !== 1'b0 || rd_w_v_o !== 2'b11) begin
      errors++; $display("FAIL mid_fill got e=%b v=%b exp e=0 v=11", queue_empty_o, rd_w_v_o);
    end
    idle_inputs();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++;
    if (rd_w_v_o !== 2'b00 || queue_empty_o !== 1'b1) begin
      errors++; $display("FAIL mid_reset got v=%b e=%b exp v=00 e=1", rd_w_v_o, queue_empty_o);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (rd_w_v_o !== 2'b00) begin
        errors++; $display("FAIL mid_nodrain c=%0d got %b exp 00", c, rd_w_v_o);
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset_i = 1'b1;
    test_reset();
    test_pipe();
    test_round_robin();
    test_full_drain();
    test_x0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
